slice_ctrl_nway: RTL and testbench

//  Next-generation slicing sequencer: measures stock length with the ultrasonic ranger, then advances
//  and cuts it into any number of equal slices (not only powers of 2), then returns and flags finish.

---
 rtl/slice_ctrl_nway.sv | 203 ++++++++++++++++++++
 tb/tb_slice_ctrl_nway.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/slice_ctrl_nway.sv
// Slicing sequencer: ranges the stock, divides it into nsl equal segments, advances and cuts
// each one, then backs the stock out. Includes echo-timeout retry, pause/resume and abort.
module slice_ctrl_nway #(
  parameter int DIS_W       = 17,
  parameter int CNT_W       = 6,
  parameter int STABLE_CYC  = 2500,
  parameter int TIMEOUT_CYC = 50000,
  parameter int MAX_RETRY   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic [CNT_W-1:0] slice_num,
  input  logic             valid,
  input  logic [DIS_W-1:0] distance,
  input  logic             trig_done,
  output logic             trigger,
  output logic             move,
  output logic             back,
  input  logic             cut_end,
  output logic             cut,
  output logic             finish,
  output logic             error,
  output logic             busy,
  output logic [3:0]       state_o
);
  localparam int STW = $clog2(STABLE_CYC + 1);
  localparam int TOW = $clog2(TIMEOUT_CYC);
  localparam int RTW = $clog2(MAX_RETRY + 1);
  localparam int DCW = $clog2(DIS_W);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_INIT_TRI = 4'd1, S_INIT_MEA = 4'd2, S_DIV = 4'd3, S_TRIG = 4'd4,
    S_MEAS = 4'd5, S_CUT = 4'd6, S_BACK_TRI = 4'd7, S_BACK = 4'd8, S_PAUSE = 4'd9,
    S_ERROR = 4'd10
  } state_t;

  state_t           state, state_nxt, saved, retry_out;
  logic [CNT_W-1:0] nsl, cut_cnt, rem, rem_nx;
  logic [RTW-1:0]   retry;
  logic [STW-1:0]   stab, stab_nxt;
  logic [TOW-1:0]   tmo;
  logic [DCW-1:0]   dcnt;
  logic [DIS_W-1:0] length, location, segment, tgt, tgt_calc;
  logic [CNT_W:0]   rem_sh, rem_sub;
  logic             div_ge, tmo_hit, start_ok, can_pause, done;
  logic             trigger_d, move_d, back_d, cut_d, error_d, busy_d;

  function automatic logic is_trig(state_t s);
    return s inside {S_INIT_TRI, S_TRIG, S_BACK_TRI};
  endfunction

  function automatic logic is_meas(state_t s);
    return s inside {S_INIT_MEA, S_MEAS, S_BACK};
  endfunction

  // A measure state falls back to its own trigger state (on retry and on resume).
  function automatic state_t trig_of(state_t s);
    case (s)
      S_INIT_MEA: return S_INIT_TRI;
      S_MEAS:     return S_TRIG;
      S_BACK:     return S_BACK_TRI;
      default:    return s;
    endcase
  endfunction

  assign tgt_calc  = (segment > location) ? '0 : location - segment;
  assign tmo_hit   = !valid && (tmo == TOW'(TIMEOUT_CYC - 1));
  assign start_ok  = start && (state == S_IDLE || state == S_ERROR);
  assign can_pause = !(state inside {S_IDLE, S_ERROR, S_DIV, S_PAUSE});
  assign retry_out = (retry == RTW'(MAX_RETRY)) ? S_ERROR : trig_of(state);

  // One restoring-division step; the quotient shifts into segment as the dividend shifts out.
  assign rem_sh  = {rem, segment[DIS_W-1]};
  assign rem_sub = rem_sh - {1'b0, nsl};
  assign div_ge  = rem_sh >= {1'b0, nsl};
  assign rem_nx  = div_ge ? rem_sub[CNT_W-1:0] : rem_sh[CNT_W-1:0];

  assign stab_nxt = (is_trig(state) && state_nxt == state)
                  ? ((stab == STW'(STABLE_CYC)) ? stab : stab + 1'b1) : '0;

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    if (abort)                        state_nxt = S_IDLE;
    else if (pause && can_pause)      state_nxt = S_PAUSE;
    else if (pause && state == S_PAUSE) state_nxt = saved;
    else begin
      case (state)
        S_IDLE, S_ERROR:
          if (start) begin
            if (slice_num < CNT_W'(2)) begin
              state_nxt = S_IDLE;
              done      = 1'b1;
            end else state_nxt = S_INIT_TRI;
          end
        S_INIT_TRI: if (trig_done) state_nxt = S_INIT_MEA;
        S_TRIG:     if (trig_done) state_nxt = S_MEAS;
        S_BACK_TRI: if (trig_done) state_nxt = S_BACK;
        S_INIT_MEA:
          if (valid)        state_nxt = S_DIV;
          else if (tmo_hit) state_nxt = retry_out;
        S_DIV: if (dcnt == DCW'(DIS_W - 1)) state_nxt = S_TRIG;
        S_MEAS:
          if (valid)        state_nxt = (distance <= tgt_calc) ? S_CUT : S_TRIG;
          else if (tmo_hit) state_nxt = retry_out;
        S_CUT:
          if (cut_end) state_nxt = (cut_cnt == nsl - CNT_W'(1)) ? S_BACK_TRI : S_TRIG;
        S_BACK:
          if (valid) begin
            if (distance >= length) begin
              state_nxt = S_IDLE;
              done      = 1'b1;
            end else state_nxt = S_BACK_TRI;
          end else if (tmo_hit) state_nxt = retry_out;
        default: ;
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered values line up with the state.
  always_comb begin
    trigger_d = is_trig(state_nxt) && (state_nxt == state) && (stab_nxt == STW'(STABLE_CYC));
    move_d    = (state_nxt == S_MEAS) || (state_nxt == S_BACK);
    back_d    = (state_nxt == S_BACK);
    cut_d     = (state_nxt == S_CUT);
    error_d   = (state_nxt == S_ERROR);
    busy_d    = !(state_nxt == S_IDLE || state_nxt == S_ERROR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      saved    <= S_IDLE;
      nsl      <= '0;
      cut_cnt  <= '0;
      retry    <= '0;
      stab     <= '0;
      tmo      <= '0;
      dcnt     <= '0;
      rem      <= '0;
      length   <= '0;
      location <= '0;
      segment  <= '0;
      tgt      <= '0;
      trigger  <= 1'b0;
      move     <= 1'b0;
      back     <= 1'b0;
      cut      <= 1'b0;
      finish   <= 1'b0;
      error    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state <= state_nxt;
      stab  <= stab_nxt;
      tmo   <= (is_meas(state) && state_nxt == state) ? tmo + 1'b1 : '0;
      if (state_nxt == S_PAUSE && state != S_PAUSE) saved <= trig_of(state);

      if (start_ok && !abort) begin
        nsl     <= slice_num;
        cut_cnt <= '0;
        retry   <= '0;
      end else if (is_meas(state) && valid) begin
        retry <= '0;
      end else if (is_meas(state) && tmo_hit && state_nxt == trig_of(state)) begin
        retry <= retry + 1'b1;
      end

      if (state == S_INIT_MEA && state_nxt == S_DIV) begin
        length   <= distance;
        location <= distance;
        segment  <= distance;
        rem      <= '0;
        dcnt     <= '0;
      end
      if (state == S_DIV && state_nxt != S_IDLE) begin
        segment <= {segment[DIS_W-2:0], div_ge};
        rem     <= rem_nx;
        dcnt    <= dcnt + 1'b1;
      end
      if (state == S_MEAS && state_nxt == S_CUT) begin
        cut_cnt <= cut_cnt + 1'b1;
        tgt     <= tgt_calc;
      end
      if (state == S_CUT && (state_nxt == S_TRIG || state_nxt == S_BACK_TRI)) begin
        location <= tgt;
        if (state_nxt == S_BACK_TRI) cut_cnt <= '0;
      end

      trigger <= trigger_d;
      move    <= move_d;
      back    <= back_d;
      cut     <= cut_d;
      finish  <= done;
      error   <= error_d;
      busy    <= busy_d;
    end
  end

  assign state_o = state;
endmodule

// File: tb/tb_slice_ctrl_nway.sv
// Bench for slice_ctrl_nway: reactive ranger/cutter models plus a scoreboard of expected cut
// and finish distances computed from the requested job.
module tb_slice_ctrl_nway;
  localparam int DW = 17, CW = 6, SC = 20, TC = 200, MR = 3;
  localparam logic [3:0] ST_IDLE = 4'd0, ST_DIV = 4'd3, ST_TRIG = 4'd4, ST_MEAS = 4'd5,
                         ST_CUT = 4'd6, ST_BACK = 4'd8, ST_PAUSE = 4'd9, ST_ERROR = 4'd10;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, pause = 1'b0, abort = 1'b0;
  logic valid = 1'b0, trig_done = 1'b0, cut_end = 1'b0;
  logic [CW-1:0] slice_num = '0;
  logic [DW-1:0] distance = '0;
  logic trigger, move, back, cut, finish, error, busy;
  logic [3:0] state_o;

  slice_ctrl_nway #(.DIS_W(DW), .CNT_W(CW), .STABLE_CYC(SC), .TIMEOUT_CYC(TC), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .abort(abort),
    .slice_num(slice_num), .valid(valid), .distance(distance), .trig_done(trig_done),
    .trigger(trigger), .move(move), .back(back), .cut_end(cut_end), .cut(cut),
    .finish(finish), .error(error), .busy(busy), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int cut_q[$], fin_q[$];
  int pos = 0, stp = 50, last_dist = 0, rwait = 0, cwait = 0, fin_cnt = 0;
  bit dead = 0, rbusy = 0, cpend = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  // One cycle: clear pulses, then let the ranger/cutter models react to the DUT outputs.
  task automatic tick();
    @(negedge clk);
    start = 0; pause = 0; abort = 0; valid = 0; trig_done = 0; cut_end = 0;
    if (trigger && !rbusy) begin
      trig_done = 1; rbusy = 1; rwait = 3;
    end else if (rbusy) begin
      if (rwait > 0) rwait--;
      else begin
        rbusy = 0;
        if (move && !back) begin
          if (!dead) begin
            pos -= stp; valid = 1;
          end
        end else begin
          if (move && back) pos += stp;
          valid = 1;
        end
        if (valid) begin
          distance = DW'(pos); last_dist = pos;
        end
      end
    end
    if (cut) begin
      if (!cpend) begin
        cpend = 1; cwait = 2;
        chk("cut_expected", cut_q.size() > 0, 1);
        if (cut_q.size() > 0) chk("cut_dist", last_dist, cut_q.pop_front());
      end else if (cwait > 0) cwait--;
      else begin
        cut_end = 1; cpend = 0;
      end
    end
    if (finish) begin
      fin_cnt++;
      if (fin_q.size() > 0) chk("fin_dist", last_dist, fin_q.pop_front());
    end
  endtask

  // Queue the distances at which cuts and the finish must occur for this job.
  task automatic start_job(input int len, input int n, input int step);
    int seg, loc, tgt, p;
    pos = len; stp = step;
    if (n >= 2) begin
      seg = len / n; loc = len; p = len;
      for (int k = 1; k < n; k++) begin
        tgt = (seg > loc) ? 0 : loc - seg;
        while (p > tgt) p -= step;
        cut_q.push_back(p);
        loc = tgt;
      end
      while (p < len) p += step;
      fin_q.push_back(p);
    end
    slice_num = CW'(n); start = 1;
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget);
    int n = 0;
    while (state_o !== s && n < budget) begin tick(); n++; end
    chk($sformatf("reach_state_%0d", s), state_o, s);
  endtask

  task automatic wait_fin(input int budget);
    int n = 0;
    while (finish !== 1'b1 && n < budget) begin tick(); n++; end
    chk("finish_seen", finish, 1);
  endtask

  initial begin
    int n, f0, ntrig, gap, min_gap;
    bit seen, prev;
    repeat (3) tick();
    chk("rst_outs", {trigger, move, back, cut, finish, error, busy}, 0);
    chk("rst_state", state_o, ST_IDLE);
    rst_n = 1; tick();

    // five slices of 1000
    start_job(1000, 5, 50);
    wait_fin(20000);
    tick();
    chk("fin_one_cycle", finish, 0);
    chk("busy_after", busy, 0);
    chk("cuts_done", cut_q.size(), 0);
    chk("fin_count", fin_cnt, 1);

    // uneven split exercises the floor division
    start_job(200, 7, 3);
    wait_fin(20000);
    chk("div_cuts_done", cut_q.size(), 0);
    chk("div_fin_done", fin_q.size(), 0);

    // single slice finishes at once
    f0 = fin_cnt;
    start_job(200, 1, 50);
    tick();
    chk("n1_finish", finish, 1);
    seen = trigger || move;
    repeat (10) begin tick(); if (trigger || move) seen = 1; end
    chk("n1_quiet", seen, 0);
    chk("n1_fin_count", fin_cnt - f0, 1);

    // echo never arrives in MEAS
    dead = 1;
    start_job(1000, 4, 50);
    wait_state(ST_TRIG, 2000);
    ntrig = 0; gap = 0; min_gap = 1000000; prev = 0; n = 0;
    while (!error && n < 5000) begin
      tick(); n++; gap++;
      if (trigger && !prev) begin
        if (ntrig > 0 && gap < min_gap) min_gap = gap;
        ntrig++; gap = 0;
      end
      prev = trigger;
    end
    chk("retrig_count", ntrig, MR + 1);
    chk("retrig_spacing", min_gap >= SC, 1);
    chk("error_flag", error, 1);
    chk("error_state", state_o, ST_ERROR);
    chk("error_not_busy", busy, 0);
    cut_q.delete(); fin_q.delete(); dead = 0; rbusy = 0;
    start_job(100, 1, 50);
    tick();
    chk("error_cleared", error, 0);
    chk("error_start_fin", finish, 1);

    // pause in MEAS, later pause in CUT
    start_job(1000, 3, 50);
    wait_state(ST_MEAS, 2000);
    pause = 1; rbusy = 0;
    tick();
    chk("pause_state", state_o, ST_PAUSE);
    chk("pause_outs", {trigger, move, back, cut, finish, error}, 0);
    repeat (5) tick();
    pause = 1;
    tick();
    chk("resume_trig", state_o, ST_TRIG);
    n = 0;
    while (!trigger && n < 100) begin tick(); n++; end
    chk("resume_stable_wait", n, SC);
    wait_state(ST_CUT, 5000);
    pause = 1;
    tick();
    chk("cut_paused", cut, 0);
    chk("cut_pause_state", state_o, ST_PAUSE);
    repeat (4) tick();
    pause = 1;
    tick();
    chk("cut_resumed", cut, 1);
    chk("cut_resume_state", state_o, ST_CUT);
    wait_fin(20000);
    chk("pause_cuts_done", cut_q.size(), 0);
    chk("pause_fin_done", fin_q.size(), 0);

    // abort beats pause in BACK
    start_job(1000, 2, 50);
    wait_state(ST_BACK, 5000);
    f0 = fin_cnt;
    abort = 1; pause = 1; rbusy = 0;
    tick();
    chk("abort_state", state_o, ST_IDLE);
    chk("abort_outs", {trigger, move, back, cut, finish, error, busy}, 0);
    repeat (30) tick();
    chk("abort_no_finish", fin_cnt - f0, 0);
    chk("abort_cuts_done", cut_q.size(), 0);
    fin_q.delete();

    // reset in the middle of the divide
    start_job(1000, 5, 50);
    wait_state(ST_DIV, 2000);
    repeat (3) tick();
    rst_n = 0;
    tick();
    chk("rst_div_state", state_o, ST_IDLE);
    chk("rst_div_outs", {trigger, move, back, cut, finish, error, busy}, 0);
    rst_n = 1; rbusy = 0; cpend = 0;
    cut_q.delete(); fin_q.delete();
    tick();
    chk("rst_div_idle", state_o, ST_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
